// File: rtl/mem_access_ctrl.sv
// Sequencer between the CPU load/store path and the ram512x8 data memory.
// Optional alignment fault checking is enabled by defining MEMCTL_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        ld,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        ram_en,
  output logic [1:0]  ram_rw,
  output logic [8:0]  ram_adr,
  output logic [31:0] ram_data,
  output logic [1:0]  ram_dataSize,
  output logic [1:0]  ram_dataPlace,
  input  logic [31:0] ram_out,
  input  logic        ram_finished
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_q, ld_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ram_en_q, ram_en_d;
  logic [1:0]       ram_rw_q, ram_rw_d;
  logic [8:0]       ram_adr_q, ram_adr_d;
  logic [31:0]      ram_data_q, ram_data_d;
  logic [1:0]       ram_size_q, ram_size_d;
  logic [1:0]       ram_place_q, ram_place_d;
  logic             misalign;

`ifdef MEMCTL_ALIGN_CHECK_EN
  assign misalign = ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  function automatic logic [31:0] mask_to_size(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {24'h0, d[7:0]};
      2'b01:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] sz, input logic s,
                                              input logic [31:0] d);
    case (sz)
      2'b00:   return {{24{s & d[7]}}, d[7:0]};
      2'b01:   return {{16{s & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_d        = ld_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_adr_d   = ram_adr_q;
    ram_data_d  = ram_data_q;
    ram_size_d  = ram_size_q;
    ram_place_d = ram_place_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          ld_d   = ld;
          size_d = size;
          sgn_d  = sgn;
          if ((size == 2'b11) || misalign) begin
            // Rejected requests never touch the RAM fields.
            state_d = S_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d     = S_ISSUE;
            ram_en_d    = 1'b1;
            ram_rw_d    = {1'b0, ld};
            ram_adr_d   = {addr[8:2], 2'b00};
            ram_data_d  = mask_to_size(size, wdata);
            ram_size_d  = size;
            ram_place_d = addr[1:0];
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the last allowed cycle still counts as success.
        if (ram_finished) begin
          state_d  = S_RESP;
          ram_en_d = 1'b0;
          done_d   = 1'b1;
          rdata_d  = ld_q ? extend_load(size_q, sgn_q, ram_out) : 32'h0;
        end else if (cnt_q == '0) begin
          state_d  = S_RESP;
          ram_en_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ld_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 2'd1;
      ram_adr_q   <= 9'h0;
      ram_data_q  <= 32'h0;
      ram_size_q  <= 2'b00;
      ram_place_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_q        <= ld_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_adr_q   <= ram_adr_d;
      ram_data_q  <= ram_data_d;
      ram_size_q  <= ram_size_d;
      ram_place_q <= ram_place_d;
    end
  end

  assign rdata         = rdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = busy_q;
  assign ram_en        = ram_en_q;
  assign ram_rw        = ram_rw_q;
  assign ram_adr       = ram_adr_q;
  assign ram_data      = ram_data_q;
  assign ram_dataSize  = ram_size_q;
  assign ram_dataPlace = ram_place_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-array RAM model behind the DUT,
// and an independent byte-array reference that predicts every response.
module tb_mem_access_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, req, ld, sgn;
  logic [1:0]  size;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done, err, busy, ram_en;
  logic [1:0]  ram_rw, ram_dataSize, ram_dataPlace;
  logic [8:0]  ram_adr;
  logic [31:0] ram_data, ram_out;
  logic        ram_finished;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .ld(ld), .size(size), .sgn(sgn),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .busy(busy), .ram_en(ram_en), .ram_rw(ram_rw), .ram_adr(ram_adr),
    .ram_data(ram_data), .ram_dataSize(ram_dataSize),
    .ram_dataPlace(ram_dataPlace), .ram_out(ram_out),
    .ram_finished(ram_finished)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct {
    logic [8:0] adr; logic [1:0] place; logic [1:0] sz; logic [1:0] rw; logic [31:0] data;
  } ramx_t;

  resp_t       sb_q[$];
  ramx_t       rx_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  ref_mem[512];
  logic [7:0]  ram_mem[512];
  int          ram_lat = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] size_mask(input int nb);
    return (nb == 1) ? 32'h0000_00FF : (nb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // RAM model: raises finished once ram_en has been high for ram_lat cycles (0 = never).
  initial begin
    int en_cyc;
    ram_finished = 1'b0;
    ram_out      = 32'h0;
    en_cyc       = 0;
    forever begin
      @(posedge clk); #1;
      if (ram_en && !ram_finished) begin
        en_cyc++;
        if (ram_lat != 0 && en_cyc == ram_lat) begin
          int nb;
          int idx;
          logic [31:0] o;
          nb = (ram_dataSize == 2'b00) ? 1 : (ram_dataSize == 2'b01) ? 2 : 4;
          o  = 32'h0;
          for (int i = 0; i < nb; i++) begin
            idx = (nb == 4) ? (int'(ram_adr) + i) : (int'(ram_adr) + ((int'(ram_dataPlace) + i) & 3));
            if (ram_rw == 2'd0) ram_mem[idx] = ram_data[8*i +: 8];
            else                o = o | (32'(ram_mem[idx]) << (8 * i));
          end
          ram_out      = o;
          ram_finished = 1'b1;
        end
      end else begin
        ram_finished = 1'b0;
        en_cyc       = 0;
      end
    end
  end

  // Response monitor: every done pulse must match the oldest predicted response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          r = sb_q.pop_front();
          check("rdata", rdata, r.rdata);
          check("err", 32'(err), 32'(r.err));
          check("busy_in_resp", 32'(busy), 32'h1);
        end
      end
    end
  end

  // RAM-side monitor: each ram_en rise must match a predicted access, fields hold while high.
  initial begin
    ramx_t x;
    logic  en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_prev = 1'b0;
      end else begin
        if (ram_en && !en_prev) begin
          if (rx_q.size() == 0) begin
            check("unexpected_ram_en", 32'(ram_en), 32'h0);
          end else begin
            x = rx_q.pop_front();
            check("ram_adr", 32'(ram_adr), 32'(x.adr));
            check("ram_dataPlace", 32'(ram_dataPlace), 32'(x.place));
            check("ram_dataSize", 32'(ram_dataSize), 32'(x.sz));
            check("ram_rw", 32'(ram_rw), 32'(x.rw));
            check("ram_data", ram_data, x.data);
          end
        end else if (ram_en) begin
          check("ram_stable_ctl", {17'h0, ram_dataPlace, ram_dataSize, ram_rw, ram_adr},
                {17'h0, x.place, x.sz, x.rw, x.adr});
          check("ram_stable_data", ram_data, x.data);
        end
        en_prev = ram_en;
      end
    end
  end

  task automatic do_req(input logic l, input logic [1:0] sz, input logic sg,
                        input logic [8:0] a, input logic [31:0] wd, input int lat);
    resp_t       r;
    ramx_t       x;
    bit          bad;
    int          nb, exp_cyc, cyc, base;
    logic [31:0] v;
    bad = (sz == 2'b11);
`ifdef MEMCTL_ALIGN_CHECK_EN
    bad = bad || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`endif
    nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    r.err   = 1'b0;
    r.rdata = 32'h0;
    if (bad) begin
      r.err   = 1'b1;
      exp_cyc = 0;
    end else begin
      exp_cyc = (lat == 0) ? TO + 1 : lat;
      r.err   = (lat == 0);
      x.adr   = a & 9'h1FC;
      x.place = a[1:0];
      x.sz    = sz;
      x.rw    = l ? 2'd1 : 2'd0;
      x.data  = wd & size_mask(nb);
      rx_q.push_back(x);
      if (!r.err) begin
        base = (nb == 4) ? int'(a & 9'h1FC) : int'(a);
        if (l) begin
          v = 32'h0;
          for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
          if (sg && nb < 4 && v[8*nb-1]) v = v | ~size_mask(nb);
          r.rdata = v;
        end else begin
          for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
        end
      end
    end
    sb_q.push_back(r);
    ram_lat = lat;
    @(posedge clk); #1;
    req = 1'b1; ld = l; size = sz; sgn = sg; addr = a; wdata = wd;
    @(posedge clk); #1;
    // Scramble the inputs so the DUT must rely on its registered copy.
    req = 1'b0; ld = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
    addr = 9'($urandom); wdata = $urandom;
    check("busy_after_req", 32'(busy), 32'h1);
    cyc = 0;
    while (!done && cyc < TO + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) check("done_timeout", 32'(done), 32'h1);
    else       check("latency", 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    logic [1:0] sz;
    logic [8:0] a;
    int         lat;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 8'($urandom);
      ram_mem[i] = ref_mem[i];
    end
    reset = 1'b1; req = 1'b0; ld = 1'b0; size = 2'b00; sgn = 1'b0; addr = 9'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_rw", 32'(ram_rw), 32'h1);
    check("rst_ram_adr", 32'(ram_adr), 32'h0);
    check("rst_ram_data", ram_data, 32'h0);
    check("rst_ram_size", 32'(ram_dataSize), 32'h0);
    check("rst_ram_place", 32'(ram_dataPlace), 32'h0);
    reset = 1'b0;

    // Byte lanes, word readback, sign/zero extension, halfword masking.
    do_req(1'b0, 2'b00, 1'b0, 9'h010, 32'hAAAA_AA0F, 2);
    do_req(1'b0, 2'b00, 1'b0, 9'h011, 32'h5555_5502, 2);
    do_req(1'b0, 2'b00, 1'b0, 9'h012, 32'h1234_5604, 2);
    do_req(1'b0, 2'b00, 1'b0, 9'h013, 32'hFFFF_FF08, 2);
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 2);
    do_req(1'b0, 2'b00, 1'b0, 9'h010, 32'h0000_008F, 2);
    do_req(1'b1, 2'b00, 1'b1, 9'h010, 32'h0, 2);
    do_req(1'b1, 2'b00, 1'b0, 9'h010, 32'h0, 2);
    do_req(1'b0, 2'b01, 1'b0, 9'h020, 32'hDEAD_BEEF, 3);
    do_req(1'b1, 2'b01, 1'b1, 9'h020, 32'h0, 2);
    do_req(1'b1, 2'b01, 1'b0, 9'h020, 32'h0, 4);

    // Timeout, reserved size, misaligned word.
    do_req(1'b1, 2'b10, 1'b0, 9'h030, 32'h0, 0);
    do_req(1'b1, 2'b11, 1'b1, 9'h034, 32'h0, 2);
    do_req(1'b1, 2'b10, 1'b0, 9'h013, 32'h0, 2);

    // Reset while waiting on the RAM: no done, then a normal access.
    begin
      ramx_t x;
      x.adr = 9'h040; x.place = 2'b00; x.sz = 2'b10; x.rw = 2'd1; x.data = 32'h0;
      rx_q.push_back(x);
      ram_lat = 0;
      @(posedge clk); #1;
      req = 1'b1; ld = 1'b1; size = 2'b10; sgn = 1'b0; addr = 9'h040; wdata = 32'h0;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_wait_busy", 32'(busy), 32'h0);
      check("rst_wait_ram_en", 32'(ram_en), 32'h0);
      repeat (TO + 6) @(posedge clk);
      #1;
      check("rst_wait_no_done", 32'(sb_q.size()), 32'h0);
    end
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'h0, 2);

    // Randomized traffic in a small window so loads see earlier stores.
    for (int n = 0; n < 60; n++) begin
      sz  = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = 9'h100 | 9'($urandom_range(0, 31));
      if (sz == 2'b01) a[0] = 1'b0;
      if (sz == 2'b10) a[1:0] = 2'b00;
      lat = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(2, 5));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, lat);
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    check("rx_drained", 32'(rx_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
